// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM with one sync write port and a read port whose style
// (combinational for FWFT, registered-with-enable for STD) follows MODE.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         DEPTH = 3,
  parameter fifo_mode_e MODE  = FIFO_STD
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [DEPTH-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [DEPTH-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH];

  // Storage is intentionally not reset; occupancy is tracked by the control logic.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    logic unused_rd;
    assign unused_rd = ^{re_i, rst_ni};
    assign rdata_o   = mem_q[raddr_i];
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with exact fill count, almost-full/empty flags and
// sticky overflow/underflow errors; STD or FWFT read behaviour.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         DEPTH     = 3,
  parameter fifo_mode_e MODE      = FIFO_STD,
  parameter int         AF_THRESH = 2**DEPTH - 2,
  parameter int         AE_THRESH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_WR_En,
  input  logic [WIDTH-1:0] i_WR_Data,
  output logic             o_Full,
  output logic             o_Almost_Full,
  input  logic             i_RD_En,
  output logic [WIDTH-1:0] o_RD_Data,
  output logic             o_Empty,
  output logic             o_Almost_Empty,
  output logic [DEPTH:0]   o_Count,
  output logic             o_Overflow,
  output logic             o_Underflow,
  input  logic             i_Clr_Err
);

  localparam int            CW     = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(2**DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

  if (DEPTH < 1 || AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > 2**DEPTH)
  begin : g_bad_params
    $error("fifo_sync_flags: illegal DEPTH/AE_THRESH/AF_THRESH combination");
  end

  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic             ovf_d, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Full/empty gate acceptance regardless of a simultaneous opposite request.
  assign wr_acc = i_WR_En & ~full_q;
  assign rd_acc = i_RD_En & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new error event outranks a clear issued in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (i_Clr_Err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (i_WR_En && full_q)  ovf_d = 1'b1;
    if (i_RD_En && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MODE  (MODE)
  ) u_mem (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_WR_Data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // FWFT exposes stale RAM while empty; force zero so reset reads back clean.
  assign o_RD_Data      = (MODE == FIFO_FWFT && empty_q) ? '0 : mem_rdata;
  assign o_Full         = full_q;
  assign o_Almost_Full  = af_q;
  assign o_Empty        = empty_q;
  assign o_Almost_Empty = ae_q;
  assign o_Count        = count_q;
  assign o_Overflow     = ovf_q;
  assign o_Underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Drives an STD and an FWFT instance with the same stimulus and compares both
// against a queue-based model of the FIFO rules.
module tb_fifo_sync_flags;
  import fifo_pkg::*;

  localparam int ENTRIES = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;

  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [7:0] s_data;
  logic [3:0] s_count;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [7:0] f_data;
  logic [3:0] f_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_udf;
  logic [7:0] m_std;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(8), .DEPTH(3), .MODE(FIFO_STD)) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .i_WR_En(wr_en), .i_WR_Data(wr_data),
    .o_Full(s_full), .o_Almost_Full(s_af), .i_RD_En(rd_en), .o_RD_Data(s_data),
    .o_Empty(s_empty), .o_Almost_Empty(s_ae), .o_Count(s_count),
    .o_Overflow(s_ovf), .o_Underflow(s_udf), .i_Clr_Err(clr_err)
  );

  fifo_sync_flags #(.WIDTH(8), .DEPTH(3), .MODE(FIFO_FWFT)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_WR_En(wr_en), .i_WR_Data(wr_data),
    .o_Full(f_full), .o_Almost_Full(f_af), .i_RD_En(rd_en), .o_RD_Data(f_data),
    .o_Empty(f_empty), .o_Almost_Empty(f_ae), .o_Count(f_count),
    .o_Overflow(f_ovf), .o_Underflow(f_udf), .i_Clr_Err(clr_err)
  );

  function automatic void model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_std = 8'h00;
  endfunction

  // Expected: {count, empty, full, ae, af, ovf, udf, std_data, fwft_data, fwft flags}
  function automatic logic [35:0] exp_vec();
    int n = q.size();
    logic [5:0] fl = {n == 0, n == ENTRIES, n <= 1, n >= 6, m_ovf, m_udf};
    return {4'(n), fl, m_std, (n != 0) ? q[0] : 8'h00, 4'(n), fl};
  endfunction

  // FWFT data is only meaningful while the model holds entries.
  function automatic logic [35:0] obs_vec();
    return {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf, s_data,
            (q.size() != 0) ? f_data : 8'h00,
            f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf};
  endfunction

  task automatic tick(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    bit wok, rok;
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    @(posedge clk);
    wok = wr && (q.size() < ENTRIES);
    rok = rd && (q.size() > 0);
    if (wr && !wok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !rok) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    if (rok) m_std = q.pop_front();
    if (wok) q.push_back(d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    if (f_data !== 8'h00) begin
      errors++; $display("FAIL reset_fwft_data got=%h want=00", f_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tick(1'b1, 8'hAB, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || s_count !== 4'd1 || s_ae !== 1'b1 || s_empty !== 1'b0) begin
      errors++; $display("FAIL single_write got=%h want=%h", obs_vec(), exp_vec());
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || s_data !== 8'hAB || s_empty !== 1'b1) begin
      errors++; $display("FAIL single_read got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill_%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (s_ovf !== 1'b1 || s_full !== 1'b1) begin
      errors++; $display("FAIL overflow got ovf=%b full=%b want 1 1", s_ovf, s_full);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || s_data !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL drain_%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_underflow();
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || s_udf !== 1'b1 || s_count !== 4'd0) begin
      errors++; $display("FAIL underflow got=%h want=%h", obs_vec(), exp_vec());
    end
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || s_udf !== 1'b1) begin
      errors++; $display("FAIL set_beats_clear got=%h want=%h", obs_vec(), exp_vec());
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || s_udf !== 1'b0 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL clear_err got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 8'(8'h84 + i), 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || s_count !== 4'd4 || s_data !== 8'(8'h80 + i)) begin
        errors++; $display("FAIL b2b_%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    while (q.size() != 0) tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_fwft();
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || f_data !== 8'h11) begin
      errors++; $display("FAIL fwft_first got=%h want=11", f_data);
    end
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || f_data !== 8'h22) begin
      errors++; $display("FAIL fwft_advance got=%h want=22", f_data);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    while (q.size() != 5) tick(q.size() < 5, 8'($urandom), q.size() > 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec() || f_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset got=%h want=%h", obs_vec(), exp_vec());
    end
    rst_n = 1'b1;
    tick(1'b1, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || f_data !== 8'h5A) begin
      errors++; $display("FAIL post_reset_write got=%h want=%h", obs_vec(), exp_vec());
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || s_data !== 8'h5A) begin
      errors++; $display("FAIL post_reset_read got=%h want=5a", s_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
